// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes, FSM
// state encoding and the flag bundle carried alongside the result.
package alu_pkg;

   // Operation codes driven by the ALU decoder
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_MUL  = 3'b011;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   // Execute FSM: single-cycle ops never leave IDLE
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_MUL   = 1'b1;

   // Status flags held together with the registered result
   typedef struct packed {
      logic zero;
      logic overflow;
      logic illegal;
   } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier. One multiplier bit (LSB first) is
// consumed per cycle; the low WIDTH bits of the unsigned product are
// presented combinationally during the final iteration (o_last) so the
// caller can register them on the same edge the last bit is processed.
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_last,
   output logic [WIDTH-1:0] o_product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;

   logic [WIDTH-1:0] w_partial;
   logic [WIDTH-1:0] w_acc_next;
   logic             w_last;

   assign w_partial  = r_mplier[0] ? r_mcand : '0;
   assign w_acc_next = r_acc + w_partial;
   assign w_last     = r_busy & (r_cnt == CW'(WIDTH - 1));

   assign o_last     = w_last;
   assign o_product  = w_acc_next;

   // Latch operands on start, then add/shift once per cycle for WIDTH cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
      end else if (i_start) begin
         r_mcand  <= i_a;
         r_mplier <= i_b;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b1;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         if (w_last) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
         end else begin
            r_cnt  <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU. Single-cycle operations load the output registers on
// the accept edge; MUL runs on the iterative multiplier and holds off new
// operations until its result has been taken by the writeback side.
module alu_exec
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             illegal
);

   logic [0:0]       r_state;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   alu_flags_t       r_flags;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_is_mul;
   logic             w_mul_start;
   logic             w_mul_last;
   logic [WIDTH-1:0] w_mul_product;

   logic signed [WIDTH-1:0] w_a;
   logic signed [WIDTH-1:0] w_b;
   logic signed [WIDTH-1:0] w_sum;
   logic signed [WIDTH-1:0] w_diff;
   logic             w_add_ovf;
   logic             w_sub_ovf;
   logic             w_slt;

   logic [WIDTH-1:0] w_sc_result;
   logic             w_sc_ovf;
   logic             w_sc_ill;

   // Handshake: in_ready is forced low while reset is asserted
   assign w_in_ready  = ~rst & (r_state == ST_IDLE) & (~r_out_valid | out_ready);
   assign w_accept    = in_valid & w_in_ready;
   assign w_is_mul    = (alu_control == ALU_MUL);
   assign w_mul_start = w_accept & w_is_mul;

   // Signed views of the operands for add/sub/compare
   assign w_a    = src_a;
   assign w_b    = src_b;
   assign w_sum  = w_a + w_b;
   assign w_diff = w_a - w_b;

   assign w_add_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) & (w_sum[WIDTH-1]  != w_a[WIDTH-1]);
   assign w_sub_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) & (w_diff[WIDTH-1] != w_a[WIDTH-1]);
   // Less-than is the true sign of a-b: raw sign corrected by overflow
   assign w_slt     = w_diff[WIDTH-1] ^ w_sub_ovf;

   // Single-cycle result and flag selection
   always_comb begin
      w_sc_result = '0;
      w_sc_ovf    = 1'b0;
      w_sc_ill    = 1'b0;
      case (alu_control)
         ALU_ADD: begin
            w_sc_result = w_sum;
            w_sc_ovf    = w_add_ovf;
         end
         ALU_SUB: begin
            w_sc_result = w_diff;
            w_sc_ovf    = w_sub_ovf;
         end
         ALU_AND: w_sc_result = src_a & src_b;
         ALU_OR:  w_sc_result = src_a | src_b;
         ALU_SLT: w_sc_result[0] = w_slt;
         ALU_MUL: w_sc_result = '0;  // result comes from the multiplier
         default: w_sc_ill = 1'b1;   // 100 and 101
      endcase
   end

   alu_mul_iter #(
      .WIDTH     (WIDTH)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_mul_start),
      .i_a       (src_a),
      .i_b       (src_b),
      .o_last    (w_mul_last),
      .o_product (w_mul_product)
   );

   // FSM: leave IDLE only for an accepted MUL, return after the last iteration
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (w_mul_start) r_state <= ST_MUL;
            ST_MUL:  if (w_mul_last)  r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Output registers: load on single-cycle accept or MUL completion, else drain on take
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_flags     <= '0;
      end else if (w_accept && !w_is_mul) begin
         r_out_valid      <= 1'b1;
         r_result         <= w_sc_result;
         r_flags.zero     <= (w_sc_result == '0);
         r_flags.overflow <= w_sc_ovf;
         r_flags.illegal  <= w_sc_ill;
      end else if (w_mul_last) begin
         r_out_valid      <= 1'b1;
         r_result         <= w_mul_product;
         r_flags.zero     <= (w_mul_product == '0);
         r_flags.overflow <= 1'b0;
         r_flags.illegal  <= 1'b0;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = r_flags.zero;
   assign overflow  = r_flags.overflow;
   assign illegal   = r_flags.illegal;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: a table of single-cycle operations issued
// back to back, plus hand-written MUL, backpressure and reset sequences.
module tb_alu_exec;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  alu_control;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  code;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic        ov;
      logic        il;
   } vec_t;

   vec_t vecs[12];

   alu_exec #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_control (alu_control),
      .src_a       (src_a),
      .src_b       (src_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .overflow    (overflow),
      .illegal     (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for in_ready; an expired bound is a failed comparison
   task automatic wait_ready();
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk("wait_in_ready", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_z);
      int early;
      wait_ready();
      alu_control = 3'b011;
      src_a       = a;
      src_b       = b;
      in_valid    = 1'b1;
      tick();                       // accept edge
      in_valid    = 1'b0;
      src_a       = 32'hDEAD_BEEF;  // operands must have been latched
      src_b       = 32'h1234_5678;
      early = 0;
      for (int i = 1; i < 32; i++) begin
         if (out_valid !== 1'b0 || in_ready !== 1'b0) early++;
         tick();
      end
      if (out_valid !== 1'b0 || in_ready !== 1'b0) early++;
      chk({name, "_busy_window"}, early, 0);
      tick();                       // edge 32 after accept
      chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, "_result"}, result, exp_res);
      chk({name, "_flags"}, {29'd0, zero, overflow, illegal}, {29'd0, exp_z, 1'b0, 1'b0});
      tick();                       // consumed with out_ready high
      chk({name, "_drained"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      int bad;

      vecs[0]  = '{3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{3'b001, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{3'b101, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{3'b100, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[8]  = '{3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{3'b110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b0};

      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      alu_control = 3'b000;
      src_a       = '0;
      src_b       = '0;

      // Reset state
      tick();
      tick();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {29'd0, zero, overflow, illegal}, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Back-to-back single-cycle operations
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         alu_control = vecs[i].code;
         src_a       = vecs[i].a;
         src_b       = vecs[i].b;
         in_valid    = 1'b1;
         chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
         tick();
         chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("v%0d_result", i), result, vecs[i].res);
         chk($sformatf("v%0d_flags", i), {29'd0, zero, overflow, illegal},
             {29'd0, vecs[i].z, vecs[i].ov, vecs[i].il});
      end
      in_valid = 1'b0;
      tick();
      chk("table_drained", {31'd0, out_valid}, 32'd0);

      // Multiplies
      run_mul("mul_2p32", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
      run_mul("mul_3x7", 32'h0000_0003, 32'h0000_0007, 32'h0000_0015, 1'b0);
      run_mul("mul_big", 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 1'b0);

      // Backpressure: AND result held while out_ready is low
      out_ready   = 1'b0;
      alu_control = 3'b000;
      src_a       = 32'h0000_F0F0;
      src_b       = 32'h0000_FF00;
      in_valid    = 1'b1;
      tick();
      in_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid !== 1'b1 || result !== 32'h0000_F000 || in_ready !== 1'b0) bad++;
         tick();
      end
      chk("bp_hold", bad, 0);
      alu_control = 3'b001;
      src_a       = 32'h0000_0001;
      src_b       = 32'h0000_0002;
      in_valid    = 1'b1;
      tick();
      chk("bp_ignored_result", result, 32'h0000_F000);
      chk("bp_ignored_in_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_or_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_or_result", result, 32'h0000_0003);
      tick();
      chk("bp_or_drained", {31'd0, out_valid}, 32'd0);

      // Reset in the middle of a MUL
      alu_control = 3'b011;
      src_a       = 32'h0000_0003;
      src_b       = 32'h0000_0007;
      in_valid    = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      #1;
      chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mrst_result", result, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("mrst_release_in_ready", {31'd0, in_ready}, 32'd1);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid !== 1'b0) bad++;
         tick();
      end
      chk("mrst_no_stale", bad, 0);
      alu_control = 3'b010;
      src_a       = 32'h0000_0002;
      src_b       = 32'h0000_0003;
      in_valid    = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("mrst_add_valid", {31'd0, out_valid}, 32'd1);
      chk("mrst_add_result", result, 32'h0000_0005);
      chk("mrst_add_flags", {29'd0, zero, overflow, illegal}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit so the bench cannot hang
   initial begin
      #200000;
      $display("FAIL timeout got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
